// File: rtl/vpu_mem_arbiter_pkg.sv
// Shared types and defaults for the VPU SDRAM read-port arbiter.
// Holds the arbiter FSM encoding, requester indices and default bus widths.
package vpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    localparam int REQ_BG  = 0;
    localparam int REQ_SPR = 1;
    localparam int REQ_AUX = 2;

    localparam int ADDR_W_DEF  = 25;
    localparam int DATA_W_DEF  = 32;
    localparam int BURST_W_DEF = 8;

endpackage

// File: rtl/vpu_mem_arbiter_rr_picker.sv
// Combinational winner selection for vpu_mem_arbiter: an urgent mask
// overrides everything, otherwise round-robin starting at the pointer.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    input  logic [NUM_REQ-1:0] i_urgent_mask,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_valid
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [NUM_REQ-1:0]   w_hit;
    logic [IDX_W:0]       w_off;
    logic [IDX_W:0]       w_sum;
    logic [IDX_W-1:0]     w_urg_idx;

    // Rotate so bit 0 is the requester at the round-robin pointer.
    assign w_hit = i_req & i_urgent_mask;
    assign w_dbl = {i_req, i_req} >> i_rr_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    // Lowest set bit of the rotated and urgent vectors; descending scan keeps the lowest.
    always_comb begin
        w_off     = '0;
        w_urg_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_off     = w_rot[k] ? (IDX_W+1)'(k) : w_off;
            w_urg_idx = w_hit[k] ? IDX_W'(k) : w_urg_idx;
        end
    end

    assign w_sum = {1'b0, i_rr_ptr} + w_off;

    // Map rotated offset back to an absolute index, wrapping at NUM_REQ.
    always_comb begin
        if (|w_hit) begin
            o_winner = w_urg_idx;
        end else if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
            o_winner = IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ));
        end else begin
            o_winner = w_sum[IDX_W-1:0];
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/vpu_mem_arbiter.sv
// Shares the SDRAM Avalon-MM burst read port among VPU requesters, one burst at a time.
// Define VPU_ARB_URGENT_EN to let the pixel-FIFO urgent flag force the background requester.
module vpu_mem_arbiter
    import vpu_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*BURST_W-1:0]   req_burst,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic                         urgent,
    output logic [ADDR_W-1:0]            avm_address,
    output logic                         avm_read,
    output logic [BURST_W-1:0]           avm_burstcount,
    input  logic                         avm_waitrequest,
    input  logic [DATA_W-1:0]            avm_readdata,
    input  logic                         avm_readdatavalid,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e           r_state;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic                 r_urgent_grant;
    logic [NUM_REQ-1:0]   r_ready;
    logic                 r_read;
    logic [ADDR_W-1:0]    r_addr;
    logic [BURST_W-1:0]   r_burst;
    logic [BURST_W-1:0]   r_beats;

    logic [NUM_REQ-1:0]   w_urgent_mask;
    logic                 w_urgent_win;
    logic [IDX_W-1:0]     w_winner;
    logic                 w_win_valid;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [BURST_W-1:0]   w_sel_burst;
    logic [IDX_W-1:0]     w_next_ptr;
    logic                 w_beat;

`ifdef VPU_ARB_URGENT_EN
    // Urgent flag only ever promotes the background requester.
    always_comb begin
        w_urgent_mask         = '0;
        w_urgent_mask[REQ_BG] = urgent;
    end
`else
    assign w_urgent_mask = {NUM_REQ{urgent & 1'b0}};
`endif

    assign w_urgent_win = |(w_urgent_mask & req_valid);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req         (req_valid),
        .i_rr_ptr      (r_rr_ptr),
        .i_urgent_mask (w_urgent_mask),
        .o_winner      (w_winner),
        .o_valid       (w_win_valid)
    );

    // Extract the winner's address and beat count from the flattened buses.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_burst = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sel_addr  = (w_winner == IDX_W'(k)) ? req_addr[k*ADDR_W +: ADDR_W] : w_sel_addr;
            w_sel_burst = (w_winner == IDX_W'(k)) ? req_burst[k*BURST_W +: BURST_W] : w_sel_burst;
        end
    end

    assign w_next_ptr = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
    assign w_beat     = (r_state == DATA) && avm_readdatavalid;

    // Arbitration, command issue and beat counting FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_owner        <= '0;
            r_rr_ptr       <= '0;
            r_urgent_grant <= 1'b0;
            r_ready        <= '0;
            r_read         <= 1'b0;
            r_addr         <= '0;
            r_burst        <= '0;
            r_beats        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_owner        <= w_winner;
                        r_urgent_grant <= w_urgent_win;
                        r_addr         <= w_sel_addr;
                        r_burst        <= (w_sel_burst == '0) ? BURST_W'(1) : w_sel_burst;
                        r_ready        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
                        r_read         <= 1'b1;
                        r_state        <= ISSUE;
                    end else begin
                        r_ready <= '0;
                    end
                end
                ISSUE: begin
                    r_ready <= '0;
                    if (!avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_beats <= r_burst;
                        r_state <= DATA;
                    end else begin
                        r_read <= 1'b1;
                    end
                end
                DATA: begin
                    r_ready <= '0;
                    if (avm_readdatavalid && (r_beats == BURST_W'(1))) begin
                        // An urgent-override grant leaves the round-robin position untouched.
                        r_rr_ptr <= r_urgent_grant ? r_rr_ptr : w_next_ptr;
                        r_owner  <= '0;
                        r_beats  <= '0;
                        r_state  <= IDLE;
                    end else if (avm_readdatavalid) begin
                        r_beats <= r_beats - BURST_W'(1);
                    end else begin
                        r_beats <= r_beats;
                    end
                end
                default: begin
                    r_ready <= '0;
                    r_read  <= 1'b0;
                    r_owner <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready      = r_ready;
    assign avm_read       = r_read;
    assign avm_address    = r_addr;
    assign avm_burstcount = r_burst;
    assign busy           = (r_state != IDLE);
    assign owner          = r_owner;
    assign rsp_valid      = w_beat ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner) : '0;
    assign rsp_data       = w_beat ? avm_readdata : '0;

endmodule

// File: tb/tb_vpu_mem_arbiter.sv
// Randomized scoreboard bench for vpu_mem_arbiter against a high-level arbitration model.
module tb_vpu_mem_arbiter;

`ifdef VPU_ARB_URGENT_EN
    localparam bit URG = 1'b1;
`else
    localparam bit URG = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [74:0] req_addr;
    logic [23:0] req_burst;
    logic [2:0]  req_ready;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_valid;
    logic        urgent;
    logic [24:0] avm_address;
    logic        avm_read;
    logic [7:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy;
    logic [1:0]  owner;

    vpu_mem_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_burst(req_burst), .req_ready(req_ready), .rsp_data(rsp_data),
        .rsp_valid(rsp_valid), .urgent(urgent), .avm_address(avm_address),
        .avm_read(avm_read), .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int owner; int burst; } cmd_t;
    typedef struct { int owner; logic [31:0] data; bit last; } beat_t;

    cmd_t  cmd_q[$];
    beat_t beat_q[$];

    int checks = 0;
    int failures = 0;

    // requester-side stimulus state
    logic [2:0]  pend;
    logic [24:0] pa[3];
    logic [7:0]  pb[3];
    logic        urg_r;
    // snapshot of what the DUT sampled at the last rising edge
    logic [2:0]  arb_pend;
    logic        arb_urg;
    logic [24:0] arb_a[3];
    logic [7:0]  arb_b[3];
    // slave-side state
    bit acc_flag;
    int beats_left;
    int b_owner;
    // reference model state
    bit mon_en;
    bit prev_idle, final_prev, read_prev, wr_prev;
    bit idle_now, read_now, grant;
    int m_rr, m_owner, m_cmd_burst, w;
    bit m_urg_grant;
    logic [24:0] m_cmd_addr;
    logic [2:0]  exp_rdy;
    beat_t mb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Arbitration rule: urgent background wins, else first pending from the pointer onward.
    function automatic int model_winner(input logic [2:0] p, input int rr, input logic u);
        if (URG && u && p[0]) return 0;
        for (int k = 0; k < 3; k++) begin
            if (p[(rr + k) % 3]) return (rr + k) % 3;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < 3; i++) begin
            req_addr[i*25 +: 25] = pa[i];
            req_burst[i*8 +: 8]  = pb[i];
        end
        urgent = urg_r;
    endtask

    task automatic step(input bit gen);
        cmd_t  c;
        beat_t b;
        @(posedge clk);
        #1;
        arb_pend = pend;
        arb_urg  = urg_r;
        for (int i = 0; i < 3; i++) begin
            arb_a[i] = pa[i];
            arb_b[i] = pb[i];
        end
        if (acc_flag) begin
            acc_flag = 1'b0;
            chk("cmd_expected", 64'(cmd_q.size() > 0), 64'd1);
            if (cmd_q.size() > 0) begin
                c = cmd_q.pop_front();
                beats_left = c.burst;
                b_owner = c.owner;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (req_ready[i]) pend[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (gen && !pend[i] && $urandom_range(0, 99) < 30) begin
                pend[i] = 1'b1;
                pa[i] = 25'($urandom);
                pb[i] = 8'($urandom_range(0, 5));
            end else if (gen && pend[i] && $urandom_range(0, 99) < 3) begin
                pend[i] = 1'b0;
            end
        end
        urg_r = gen ? ($urandom_range(0, 3) == 0) : 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
        avm_waitrequest = 1'($urandom_range(0, 1));
        if (beats_left > 0) begin
            if ($urandom_range(0, 9) < 7) begin
                avm_readdatavalid = 1'b1;
                beats_left--;
                b.owner = b_owner;
                b.data = avm_readdata;
                b.last = (beats_left == 0);
                beat_q.push_back(b);
            end
        end else if (avm_read) begin
            if ($urandom_range(0, 2) != 0) begin
                avm_waitrequest = 1'b0;
                acc_flag = 1'b1;
            end else begin
                avm_waitrequest = 1'b1;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            avm_readdatavalid = 1'b1;
        end
        drive();
    endtask

    // Monitor: predicts grants, command and beats each cycle and pops the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            grant = 1'b0;
            exp_rdy = 3'b000;
            if (prev_idle && arb_pend != 3'b000) begin
                w = model_winner(arb_pend, m_rr, arb_urg);
                grant = 1'b1;
                exp_rdy = 3'b001 << w;
                m_owner = w;
                m_urg_grant = URG && arb_urg && arb_pend[0];
                m_cmd_addr = arb_a[w];
                m_cmd_burst = (arb_b[w] == 8'd0) ? 1 : int'(arb_b[w]);
                cmd_q.push_back('{owner: w, burst: m_cmd_burst});
            end
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            idle_now = (prev_idle && !grant) || final_prev;
            read_now = grant || (read_prev && wr_prev);
            chk("avm_read", 64'(avm_read), 64'(read_now));
            if (read_now) begin
                chk("avm_address", 64'(avm_address), 64'(m_cmd_addr));
                chk("avm_burstcount", 64'(avm_burstcount), 64'(m_cmd_burst));
            end
            chk("busy", 64'(busy), 64'(!idle_now));
            chk("owner", 64'(owner), idle_now ? 64'd0 : 64'(m_owner));
            final_prev = 1'b0;
            if (beat_q.size() > 0) begin
                mb = beat_q.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(3'b001 << mb.owner));
                chk("rsp_data", 64'(rsp_data), 64'(mb.data));
                if (mb.last) begin
                    final_prev = 1'b1;
                    if (!m_urg_grant) m_rr = (m_owner + 1) % 3;
                end
            end else begin
                chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
            end
            prev_idle = idle_now;
            read_prev = read_now;
            wr_prev = avm_waitrequest;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_avm_read"}, 64'(avm_read), 64'd0);
        chk({tag, "_avm_address"}, 64'(avm_address), 64'd0);
        chk({tag, "_avm_burstcount"}, 64'(avm_burstcount), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_owner"}, 64'(owner), 64'd0);
    endtask

    initial begin
        int  quiet;
        bit  seen;
        rst = 1'b1;
        pend = 3'b000;
        urg_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pa[i] = 25'd0;
            pb[i] = 8'd0;
        end
        avm_waitrequest = 1'b1;
        avm_readdata = 32'd0;
        avm_readdatavalid = 1'b0;
        acc_flag = 1'b0;
        beats_left = 0;
        b_owner = 0;
        mon_en = 1'b0;
        prev_idle = 1'b1;
        final_prev = 1'b0;
        read_prev = 1'b0;
        wr_prev = 1'b0;
        m_rr = 0;
        m_owner = 0;
        m_urg_grant = 1'b0;
        arb_pend = 3'b000;
        arb_urg = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        for (int cyc = 0; cyc < 2500; cyc++) step(1'b1);

        quiet = 0;
        for (int cyc = 0; cyc < 600 && quiet < 4; cyc++) begin
            step(1'b0);
            if (pend == 3'b000 && beats_left == 0 && !acc_flag && !avm_read &&
                cmd_q.size() == 0 && beat_q.size() == 0)
                quiet++;
            else
                quiet = 0;
        end
        chk("drain_done", 64'(quiet >= 4), 64'd1);
        mon_en = 1'b0;

        // Directed: reset after 2 of 8 beats drops the burst and later beats.
        @(posedge clk);
        #1;
        pa[1] = 25'h100;
        pb[1] = 8'd8;
        pend = 3'b010;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        drive();
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(posedge clk);
            #1;
            seen = req_ready[1];
        end
        chk("dir_ready_seen", 64'(seen), 64'd1);
        pend = 3'b000;
        drive();
        chk("dir_avm_read", 64'(avm_read), 64'd1);
        chk("dir_avm_address", 64'(avm_address), 64'h100);
        chk("dir_avm_burstcount", 64'(avm_burstcount), 64'd8);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            avm_readdatavalid = 1'b1;
            avm_readdata = 32'hA0 + 32'(k);
            @(negedge clk);
            chk("dir_beat_valid", 64'(rsp_valid), 64'h2);
            chk("dir_beat_data", 64'(rsp_data), 64'(32'hA0 + 32'(k)));
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        avm_readdata = 32'hDEAD;
        @(negedge clk);
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end
        avm_readdatavalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vpu_mem_arbiter.md
# vpu_mem_arbiter

Arbiter that shares the single Avalon-MM read port of the SDRAM controller between the VPU's memory requesters: background loader (requester 0), sprite loader (requester 1) and CPU/aux fetch (requester 2). It runs in the system clock domain between the requesters and the SDRAM controller slave. It grants one burst read at a time and routes the returned beats to the owning requester. It gives background fetches urgent priority when the dual-clock pixel FIFO runs low.

## Interface
- NUM_REQ, 3, number of requesters; index 0 is the background requester.
- ADDR_W, 25, byte address width of the SDRAM slave.
- DATA_W, 32, data width; matches the 32-bit DRAM_DQ.
- BURST_W, 8, burstcount width; maximum burst is 2^BURST_W−1 beats.
- clk  in  1  system clock (clk_sys domain).
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request pending.
- req_addr  in  NUM_REQ*ADDR_W  flattened per-requester start address.
- req_burst  in  NUM_REQ*BURST_W  flattened per-requester beat count.
- req_ready  out  NUM_REQ  one-cycle pulse when that requester's request is latched.
- rsp_data  out  DATA_W  read data, broadcast to all requesters.
- rsp_valid  out  NUM_REQ  one-hot beat strobe to the owner.
- urgent  in  1  pixel-FIFO low-watermark flag, synchronous to clk.
- avm_address  out  ADDR_W  Avalon address.
- avm_read  out  1  Avalon read.
- avm_burstcount  out  BURST_W  Avalon burst length.
- avm_waitrequest  in  1  Avalon stall.
- avm_readdata  in  DATA_W  Avalon read data.
- avm_readdatavalid  in  1  Avalon data beat.
- busy  out  1  high when not in IDLE.
- owner  out  $clog2(NUM_REQ)  index of the current grant holder; 0 when idle.

## Operation
- FSM states: IDLE, ISSUE, DATA.
- IDLE:
  - If any req_valid is set, select a winner: urgent override (see Configuration), otherwise round-robin starting at rr_ptr.
  - Latch the winner's addr and burst, pulse req_ready[winner], and go to ISSUE.
  - A req_burst of 0 is latched as 1.
- ISSUE:
  - Hold avm_read=1 with the latched address and burstcount.
  - When avm_waitrequest=0, drop avm_read, load the beat counter with the burst value, and go to DATA.
- DATA:
  - Each avm_readdatavalid asserts rsp_valid[owner] in the same cycle and decrements the beat counter.
  - On the final beat, go to IDLE and set rr_ptr = owner+1 (wrapping at NUM_REQ).
- avm_readdatavalid outside DATA is ignored; rsp_valid stays 0.
- A requester holds req_valid and its addr/burst stable until it sees req_ready. Deasserting req_valid before req_ready withdraws the request without a penalty.
- At most one outstanding burst; there is no pipelining of a second command.

## Timing
- Reset values: avm_read=0, avm_address=0, avm_burstcount=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=0, owner=0, rr_ptr=0, FSM in IDLE.
- Arbitration is combinational in IDLE. req_ready is registered and coincides with the first ISSUE cycle.
- avm_read rises 1 cycle after req_valid is sampled in IDLE.
- rsp_valid and rsp_data are combinational pass-through of avm_readdatavalid and avm_readdata: zero added latency.
- IDLE is occupied for 1 cycle between bursts, so back-to-back grants have a minimum 1-cycle gap.
- Simultaneous final beat and new request: the new request is arbitrated in the following IDLE cycle.
- Reset mid-burst: return to IDLE immediately and drop in-flight beats. The SDRAM controller shares the same reset.

## Configuration
- VPU_ARB_URGENT_EN defined:
  - When urgent=1 and req_valid[0]=1, requester 0 wins regardless of rr_ptr.
  - A grant won by this override does not advance rr_ptr. It stays at its prior value so the other requesters keep their position.
- Undefined: urgent is ignored and arbitration is pure round-robin.

## Structure
- Shared package vpu_pkg holds:
  - The state enum (IDLE, ISSUE, DATA).
  - Requester index constants REQ_BG=0, REQ_SPR=1, REQ_AUX=2.
  - Default widths for ADDR_W, DATA_W and BURST_W.
- One sub-module, rr_picker: purely combinational. Inputs are the request vector, rr_ptr and urgent_mask; output is the winner index and a valid flag.

## Test plan
- Single request: req 1 with addr 0x100, burst 4, waitrequest low → avm_read for 1 cycle with burstcount 4; four rsp_valid[1] pulses carrying 0xA0..0xA3; busy falls after the 4th beat.
- Round-robin: all three requesters held valid with burst 1 → grant order 0,1,2,0; req_ready pulses in that order.
- Stall: avm_waitrequest high for 5 cycles → avm_read, avm_address and avm_burstcount held stable for 6 cycles; no req_ready pulse for any other requester.
- Urgent (macro defined): rr_ptr=1, req 0 and req 1 valid, urgent=1 → owner=0 and rr_ptr stays 1. Without the macro → owner=1.
- Burst 0: req 2 with burst 0 → avm_burstcount=1; one rsp_valid[2] beat, then IDLE.
- Reset mid-DATA: assert rst after 2 of 8 beats → all outputs return to reset values; later avm_readdatavalid produces no rsp_valid.
